// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: address map, mstatus/mcountinhibit bit positions,
// and the counter-address decoder used by both the read and write ports.
package csr_defines;

  localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;

  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MHPM3         = 12'hB03;
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_HPM3          = 12'hC03;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam int INH_CY   = 0;
  localparam int INH_IR   = 2;
  localparam int INH_HPM3 = 3;

  typedef struct packed {
    logic       valid;
    logic       ro;
    logic       hi;
    logic [4:0] idx;
  } cnt_sel_t;

  // Address offset 0 maps to counter index 0; offsets 2 and up map to index offset-1.
  // Offset 1 (time) has no counter.
  function automatic cnt_sel_t decode_cnt(input logic [11:0] addr, input int nhpm);
    cnt_sel_t s;
    logic [4:0] off;
    off     = addr[4:0];
    s.ro    = (addr[11:8] == 4'hC);
    s.hi    = addr[7];
    s.idx   = (off == 5'd0) ? 5'd0 : off - 5'd1;
    s.valid = ((addr[11:8] == 4'hC) || (addr[11:8] == 4'hB)) && (addr[6:5] == 2'b00) &&
              (off != 5'd1) && (int'(off) < 3 + nhpm);
    return s;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// One wide event counter with split 32-bit write halves; a write beats an increment.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (we_lo) begin
      cnt <= {cnt[WIDTH-1:32], wdata};
    end else if (we_hi) begin
      cnt <= {wdata[WIDTH-33:0], cnt[31:0]};
    end else if (inc && !inhibit) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: cycle/instret/hpm counters with inhibit, trap state
// registers and the atomic trap-entry / mret update path.
module csr_file
  import csr_defines::*;
#(
  parameter int          CNT_WIDTH = 64,
  parameter int          NUM_HPM   = 2,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   we_i,
  input  logic [11:0]                            waddr_i,
  input  logic [31:0]                            data_i,
  input  logic [11:0]                            raddr_i,
  output logic [31:0]                            data_o,
  output logic                                   rvalid_o,
  input  logic                                   instret_i,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
  input  logic                                   trap_i,
  input  logic [31:0]                            trap_pc_i,
  input  logic [31:0]                            trap_cause_i,
  input  logic                                   mret_i,
  output logic [31:0]                            mtvec_o,
  output logic [31:0]                            mepc_o,
  output logic                                   mie_o
);

  localparam int          NCNT     = 2 + NUM_HPM;
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << INH_HPM3);

  logic [CNT_WIDTH-1:0] cnt [NCNT];
  logic [31:0]          inh, mtvec, mepc, mcause, mscratch;
  logic                 mie, mpie;
  logic [63:0]          cnt_val;
  logic                 cnt_we;
  cnt_sel_t             wsel, rsel;

  assign wsel   = decode_cnt(waddr_i, NUM_HPM);
  assign rsel   = decode_cnt(raddr_i, NUM_HPM);
  assign cnt_we = we_i && wsel.valid && !wsel.ro;

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    logic inc, inhibit, we_lo, we_hi;
    if (i == 0) begin : g_cycle
      assign inc     = 1'b1;
      assign inhibit = inh[INH_CY];
    end else if (i == 1) begin : g_instret
      assign inc     = instret_i;
      assign inhibit = inh[INH_IR];
    end else begin : g_hpm
      assign inc     = hpm_event_i[i-2];
      assign inhibit = inh[INH_HPM3+i-2];
    end
    assign we_lo = cnt_we && (int'(wsel.idx) == i) && !wsel.hi;
    assign we_hi = cnt_we && (int'(wsel.idx) == i) && wsel.hi;

    csr_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc),
      .inhibit (inhibit),
      .we_lo   (we_lo),
      .we_hi   (we_hi),
      .wdata   (data_i),
      .cnt     (cnt[i])
    );
  end

  // Trap entry outranks CSR writes to mepc/mcause/mstatus; mret outranks mstatus writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      inh      <= '0;
      mtvec    <= MTVEC_RST;
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
      mie      <= 1'b0;
      mpie     <= 1'b0;
    end else begin
      if (we_i) begin
        case (waddr_i)
          ADDR_MCOUNTINHIBIT: inh      <= data_i & INH_MASK;
          ADDR_MTVEC:         mtvec    <= {data_i[31:2], 2'b00};
          ADDR_MSCRATCH:      mscratch <= data_i;
          ADDR_MEPC:          if (!trap_i) mepc <= {data_i[31:1], 1'b0};
          ADDR_MCAUSE:        if (!trap_i) mcause <= data_i;
          ADDR_MSTATUS: begin
            if (!trap_i && !mret_i) begin
              mie  <= data_i[MSTATUS_MIE];
              mpie <= data_i[MSTATUS_MPIE];
            end
          end
          default: ;
        endcase
      end
      if (trap_i) begin
        mepc   <= {trap_pc_i[31:1], 1'b0};
        mcause <= trap_cause_i;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (mret_i) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (int'(rsel.idx) == i) cnt_val = 64'(cnt[i]);
    end
    data_o   = '0;
    rvalid_o = 1'b0;
    if (!rst) begin
      if (rsel.valid) begin
        rvalid_o = 1'b1;
        data_o   = rsel.hi ? cnt_val[63:32] : cnt_val[31:0];
      end else begin
        rvalid_o = 1'b1;
        case (raddr_i)
          ADDR_MCOUNTINHIBIT: data_o = inh;
          ADDR_MSTATUS: begin
            data_o[MSTATUS_MIE]  = mie;
            data_o[MSTATUS_MPIE] = mpie;
          end
          ADDR_MTVEC:    data_o = mtvec;
          ADDR_MSCRATCH: data_o = mscratch;
          ADDR_MEPC:     data_o = mepc;
          ADDR_MCAUSE:   data_o = mcause;
          default:       rvalid_o = 1'b0;
        endcase
      end
    end
  end

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;
  assign mie_o   = mie;

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Parametrised machine-mode CSR file for the core; next generation of the cycle-only CSR register block.
- Provides wide cycle, instret and N hardware performance counters with inhibit control, plus mstatus/mtvec/mepc/mcause/mscratch.
- Provides an atomic trap-entry/mret update path driven by the exception logic.
- Sits beside the regfile; ex stage reads/writes via CSR instructions, clint drives trap/mret.

Parameters:
- CNT_WIDTH, 64, counter width in bits; legal 33..64.
- NUM_HPM, 2, number of mhpmcounters (3..3+NUM_HPM-1); legal 0..29.
- MTVEC_RST, 32'h0, reset value of mtvec.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we_i  in  1  CSR write enable
- waddr_i  in  12  CSR write address
- data_i  in  32  CSR write data
- raddr_i  in  12  CSR read address
- data_o  out  32  CSR read data, combinational
- rvalid_o  out  1  raddr_i maps to an implemented CSR
- instret_i  in  1  one instruction retired this cycle
- hpm_event_i  in  NUM_HPM  per-counter increment events
- trap_i  in  1  trap entry this cycle
- trap_pc_i  in  32  PC to save in mepc
- trap_cause_i  in  32  value for mcause
- mret_i  in  1  mret executes this cycle
- mtvec_o  out  32  current mtvec
- mepc_o  out  32  current mepc
- mie_o  out  1  mstatus.MIE

Behaviour:
- Reset (clk edge with rst=1): all counters 0; mcountinhibit 0; mstatus 0; mepc, mcause, mscratch 0; mtvec MTVEC_RST. While rst=1, data_o=0 and rvalid_o=0.
- Address map:
  - cycle: 0xC00/0xC80 read-only, 0xB00/0xB80 writable.
  - instret: 0xC02/0xC82 read-only, 0xB02/0xB82 writable.
  - hpm i: 0xC03+i/0xC83+i read-only, 0xB03+i/0xB83+i writable.
  - mcountinhibit 0x320, mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
- Reads: same-cycle combinational, no write bypass. A read in the cycle of a write returns the pre-write value.
- Unmapped address: data_o=0, rvalid_o=0.
- Writes to unmapped or 0xCxx addresses are ignored.
- Counter high half: returns bits [CNT_WIDTH-1:32], zero-extended.
- Counters, each cycle:
  - cycle increments unless inhibit bit0 is set.
  - instret increments when instret_i=1 and inhibit bit2=0.
  - hpm i increments when hpm_event_i[i]=1 and inhibit bit 3+i=0.
- Counter wrap: 2^CNT_WIDTH-1 +1 -> 0.
- Counter write: the written half takes data_i (high half truncated to CNT_WIDTH-32 bits); the other half holds. No increment for that counter that cycle (write wins).
- mcountinhibit writable bits: 0, 2, 3..3+NUM_HPM-1; others read 0.
- mstatus: only MIE (bit3) and MPIE (bit7) stored; other bits read 0.
- mtvec: bits[1:0] forced 0 on write.
- mepc: bit0 forced 0 on write and on trap capture.
- trap_i=1:
  - mepc<=trap_pc_i, mcause<=trap_cause_i.
  - MPIE<=MIE, MIE<=0.
  - Takes precedence over a same-cycle CSR write to mepc, mcause or mstatus; writes to other CSRs proceed.
- mret_i=1 (trap_i=0): MIE<=MPIE, MPIE<=1; takes precedence over a same-cycle mstatus write.
- trap_i and mret_i both 1: trap wins, mret ignored.
- mtvec_o, mepc_o, mie_o: reflect register state (registered outputs).
- Reset mid-operation overrides every other event.

Decomposition:
- Shared package csr_defines: all CSR address constants, mstatus bit positions (MIE=3, MPIE=7), mcountinhibit bit positions.
- Sub-module csr_counter: params WIDTH; inputs inc, inhibit, we_lo, we_hi, wdata; output cnt. Instantiated 2+NUM_HPM times via generate.
- Read mux and trap/mret logic stay in csr_file.

Test Plan:
- Release reset, idle 10 cycles -> read 0xC00 returns 10 (±1 per sample point), 0xC80 returns 0; rvalid_o=1.
- Write 0xB00=32'hFFFF_FFFE, 0xB80=0; wait 3 cycles -> 0xC80 reads 1, low half reads 1 (carry across halves); with CNT_WIDTH=40, write 0xB80=32'hFFFF_FFFF -> 0xC80 reads 32'hFF.
- Write 0x320=32'h5, pulse instret_i 4 cycles -> cycle and instret frozen. Write 0x320=0, pulse instret_i 4 cycles -> instret +4. Write 0xB02=7 with instret_i=1 the same cycle -> instret reads 7.
- Set MIE via 0x300=32'h8; trap_i with pc 32'h1003, cause 32'hB, plus same-cycle write 0x341=32'h55 -> mepc=32'h1002, mcause=32'hB, mstatus reads 32'h80, mie_o=0.
- mret_i -> mstatus reads 32'h88, mie_o=1. trap_i and mret_i together -> trap semantics only.
- Write 0x305=32'h8000_0003 -> mtvec_o=32'h8000_0000. Read 0x7C0 -> data_o=0, rvalid_o=0. Write 0xC00 -> cycle unaffected.
